mem_port_mux: RTL and testbench
===============================

Name: mem_port_mux

Overview:
- Datapath stage directly downstream of the 4-way round-robin access arbiter.
- Raises each master's request toward the arbiter, then forwards the currently granted master's command to the single shared memory port.
- Routes in-order read responses back to the master that issued each read, tracking master IDs in an internal FIFO.
- Sits between the four client command channels and the memory controller.

Parameters:
- AW, 32, address width in bits
- DW, 32, data width in bits
- MAX_OUTST, 4, maximum outstanding reads; power of two, 2..16

Ports:
- sys_clk  in  1  system clock; all state updates on the rising edge
- sys_rst_n  in  1  synchronous reset, active-low
- m_cmd_valid  in  4  per-master command valid
- m_cmd_ready  out  4  per-master command accept
- m_cmd_we  in  4  per-master write enable (1 = write)
- m_cmd_addr  in  4*AW  per-master address; master i occupies bits [i*AW +: AW]
- m_cmd_wdata  in  4*DW  per-master write data, packed like m_cmd_addr
- m_rsp_valid  out  4  per-master read-response strobe, one-hot or zero
- m_rsp_rdata  out  DW  read data, shared by all masters; qualified by m_rsp_valid
- arb_request  out  4  request vector to the arbiter
- arb_grant  in  2  granted master index from the arbiter
- mem_valid  out  1  command valid to memory
- mem_ready  in  1  memory accepts the command
- mem_we  out  1  write enable to memory
- mem_addr  out  AW  address to memory
- mem_wdata  out  DW  write data to memory
- mem_rvalid  in  1  read data valid from memory; in order, one per read, no backpressure
- mem_rdata  in  DW  read data from memory
- err_orphan  out  1  sticky flag: mem_rvalid seen with no outstanding read

Behaviour:
- arb_request = m_cmd_valid, combinational.
- g = arb_grant.
- stall = outst_cnt == MAX_OUTST and m_cmd_we[g] == 0. Writes never stall on the outstanding-read limit.
- mem_valid = m_cmd_valid[g] & ~stall.
- mem_we, mem_addr, mem_wdata = slice g of the master inputs, combinational mux.
- m_cmd_ready[i] = (i == g) & mem_ready & ~stall. It is 0 for every non-granted master.
- Accept = mem_valid & mem_ready.
- On a read accept: push g into the ID FIFO and increment outst_cnt.
- On mem_rvalid: pop the FIFO head h, drive m_rsp_valid[h] = 1 in the same cycle, and set m_rsp_rdata = mem_rdata (combinational pass-through, zero latency).
- Same-cycle read accept and mem_rvalid: push and pop both occur; outst_cnt is unchanged; the FIFO is correct even when full, because the pop frees the slot written that edge.
  - Consequence: when the FIFO is full, stall still applies that cycle. Stall is not relaxed by a concurrent pop.
- mem_rvalid with an empty FIFO: no pop, m_rsp_valid = 0, err_orphan set to 1. err_orphan stays 1 until reset.
- A grant change takes effect on the same cycle the arb_grant value changes. This block has no grant-hold state; grant stability comes from the arbiter holding the grant while the request stays asserted.
- ID FIFO: MAX_OUTST entries of 2 bits; read and write pointers of clog2(MAX_OUTST) bits that wrap modulo depth; count of clog2(MAX_OUTST)+1 bits.
- Reset (sys_rst_n == 0 at a clock edge): pointers, outst_cnt and err_orphan cleared to 0.
  - Resulting outputs: mem_valid, m_cmd_ready and m_rsp_valid are 0 while reset is held.
  - Reads in flight are dropped. Their late mem_rvalid after reset sets err_orphan; the memory controller is reset in the same domain to avoid this.
- m_rsp_rdata equals mem_rdata whenever m_rsp_valid is 0; it is don't-care for masters in that case.

Decomposition:
- Shared package mem_port_pkg:
  - NUM_MASTERS = 4, ID_W = 2
  - master_id_t typedef
  - cmd struct (we, addr, wdata)
- One sub-module: mem_id_fifo.
  - Synchronous FIFO with push/pop/full/empty/count, parameterised on depth and width.
  - Reusable by any future multi-port memory stage.

Test Plan:
1. Reset + idle: hold sys_rst_n = 0 for 3 cycles with all inputs active -> mem_valid = 0, m_cmd_ready = 0, m_rsp_valid = 0, err_orphan = 0.
2. Single read: arb_grant = 2, m_cmd_valid = 4'b0100, we = 0, addr = 0x100, mem_ready = 1; mem_rvalid with rdata = 0xDEADBEEF two cycles later -> mem_addr = 0x100 on the accept cycle; m_rsp_valid = 4'b0100 and m_rsp_rdata = 0xDEADBEEF on the rvalid cycle.
3. Outstanding limit: master 0 issues 5 back-to-back reads, no mem_rvalid -> 4 accepted, then mem_valid = 0 and m_cmd_ready[0] = 0. A write from master 0 in the next cycle is still accepted. One mem_rvalid -> 5th read accepted the following cycle.
4. Interleaved masters: reads accepted in order from masters 1, 3, 0; three mem_rvalid with data 0x11, 0x33, 0x00 -> m_rsp_valid sequence 4'b0010, 4'b1000, 4'b0001 with matching data.
5. Simultaneous push/pop at full: FIFO holding 4 IDs; same-cycle mem_rvalid and a new read request -> the read stalls that cycle and is accepted the next cycle; pointer wrap leaves FIFO order intact.
6. Orphan response: after reset, mem_rvalid = 1 with nothing outstanding -> m_rsp_valid = 0, err_orphan = 1 and held. Reset -> err_orphan = 0.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types for the multi-port memory stage: master IDs, command payload, ID helper.
package mem_port_pkg;

    localparam int unsigned NUM_MASTERS = 4;
    localparam int unsigned ID_W        = 2;
    localparam int unsigned CMD_AW_MAX  = 64;
    localparam int unsigned CMD_DW_MAX  = 64;

    typedef logic [ID_W-1:0] master_id_t;

    // Widest supported command; narrower instances zero-extend into it.
    typedef struct packed {
        logic                  we;
        logic [CMD_AW_MAX-1:0] addr;
        logic [CMD_DW_MAX-1:0] wdata;
    } cmd_t;

    function automatic logic [NUM_MASTERS-1:0] id_onehot(input master_id_t id);
        logic [NUM_MASTERS-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mem_id_fifo.sv
// Synchronous FIFO for small tags; push while full is allowed when a pop frees the slot that edge.
module mem_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr];
    assign count   = cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_port_mux.sv
// Forwards the granted master's command to the shared memory port and steers
// in-order read responses back to the issuing master via an ID FIFO.
module mem_port_mux
    import mem_port_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [NUM_MASTERS-1:0]    m_cmd_valid,
    output logic [NUM_MASTERS-1:0]    m_cmd_ready,
    input  logic [NUM_MASTERS-1:0]    m_cmd_we,
    input  logic [NUM_MASTERS*AW-1:0] m_cmd_addr,
    input  logic [NUM_MASTERS*DW-1:0] m_cmd_wdata,
    output logic [NUM_MASTERS-1:0]    m_rsp_valid,
    output logic [DW-1:0]             m_rsp_rdata,
    output logic [NUM_MASTERS-1:0]    arb_request,
    input  logic [ID_W-1:0]           arb_grant,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_wdata,
    input  logic                      mem_rvalid,
    input  logic [DW-1:0]             mem_rdata,
    output logic                      err_orphan
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

    logic [NUM_MASTERS-1:0][AW-1:0] addr_arr;
    logic [NUM_MASTERS-1:0][DW-1:0] wdata_arr;
    master_id_t                     g;
    master_id_t                     head_id;
    cmd_t                           sel_cmd;
    logic                           stall;
    logic                           accept;
    logic                           rd_push;
    logic                           rsp_pop;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [CNT_W-1:0]               outst_cnt;

    assign addr_arr    = m_cmd_addr;
    assign wdata_arr   = m_cmd_wdata;
    assign g           = arb_grant;
    assign arb_request = m_cmd_valid;

    // Command mux for the granted master.
    always_comb begin
        sel_cmd       = '0;
        sel_cmd.we    = m_cmd_we[g];
        sel_cmd.addr  = CMD_AW_MAX'(addr_arr[g]);
        sel_cmd.wdata = CMD_DW_MAX'(wdata_arr[g]);
    end

    assign mem_we    = sel_cmd.we;
    assign mem_addr  = AW'(sel_cmd.addr);
    assign mem_wdata = DW'(sel_cmd.wdata);

    // Only reads are throttled; a concurrent pop does not relax the limit.
    assign stall     = fifo_full & ~sel_cmd.we;
    assign mem_valid = sys_rst_n & m_cmd_valid[g] & ~stall;
    assign accept    = mem_valid & mem_ready;
    assign rd_push   = accept & ~sel_cmd.we;
    assign rsp_pop   = sys_rst_n & mem_rvalid & ~fifo_empty;

    always_comb begin
        m_cmd_ready    = '0;
        m_cmd_ready[g] = sys_rst_n & mem_ready & ~stall;
    end

    assign m_rsp_valid = rsp_pop ? id_onehot(head_id) : '0;
    assign m_rsp_rdata = mem_rdata;

    mem_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (rd_push),
        .din   (g),
        .pop   (rsp_pop),
        .dout  (head_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outst_cnt)
    );

    // Sticky: a response arrived with nothing outstanding.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            err_orphan <= 1'b0;
        end else if (mem_rvalid && (outst_cnt == '0)) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_mux.sv
// Directed bench for mem_port_mux; read responses are checked against a queue of expected master IDs.
module tb_mem_port_mux;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic           sys_clk = 1'b0;
    logic           sys_rst_n;
    logic [3:0]     m_cmd_valid;
    logic [3:0]     m_cmd_ready;
    logic [3:0]     m_cmd_we;
    logic [4*AW-1:0] m_cmd_addr;
    logic [4*DW-1:0] m_cmd_wdata;
    logic [3:0]     m_rsp_valid;
    logic [DW-1:0]  m_rsp_rdata;
    logic [3:0]     arb_request;
    logic [1:0]     arb_grant;
    logic           mem_valid;
    logic           mem_ready;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic           mem_rvalid;
    logic [DW-1:0]  mem_rdata;
    logic           err_orphan;

    int n_chk = 0;
    int n_err = 0;
    logic [1:0] sb_q[$];

    mem_port_mux #(.AW(AW), .DW(DW), .MAX_OUTST(4)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .m_cmd_valid (m_cmd_valid),
        .m_cmd_ready (m_cmd_ready),
        .m_cmd_we    (m_cmd_we),
        .m_cmd_addr  (m_cmd_addr),
        .m_cmd_wdata (m_cmd_wdata),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_rdata (m_rsp_rdata),
        .arb_request (arb_request),
        .arb_grant   (arb_grant),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .err_orphan  (err_orphan)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [3:0] oh(input logic [1:0] id);
        logic [3:0] v;
        v = 4'b0001;
        return v << id;
    endfunction

    // Drive one read from master m, expect it accepted this cycle, record its ID.
    task automatic issue_read(input logic [1:0] m, input logic [AW-1:0] a);
        arb_grant   = m;
        m_cmd_valid = oh(m);
        m_cmd_we    = 4'b0000;
        m_cmd_addr[int'(m)*AW +: AW] = a;
        settle();
        chk("rd_mem_valid", 64'(mem_valid), 64'(1));
        chk("rd_cmd_ready", 64'(m_cmd_ready), 64'(oh(m)));
        chk("rd_mem_addr", 64'(mem_addr), 64'(a));
        sb_q.push_back(m);
        tick();
    endtask

    // Present mem_rvalid with data d and check routing against the scoreboard head.
    task automatic rsp_expect(input string tag, input logic [DW-1:0] d);
        logic [1:0] id;
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        settle();
        if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL %s: observed=response expected=no response queued", tag);
        end else begin
            id = sb_q.pop_front();
            chk({tag, "_valid"}, 64'(m_rsp_valid), 64'(oh(id)));
            chk({tag, "_rdata"}, 64'(m_rsp_rdata), 64'(d));
        end
    endtask

    initial begin
        // Reset held with every input active.
        sys_rst_n   = 1'b0;
        m_cmd_valid = 4'hF;
        m_cmd_we    = 4'h0;
        m_cmd_addr  = '0;
        m_cmd_wdata = '0;
        arb_grant   = 2'd0;
        mem_ready   = 1'b1;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'h0BAD_0BAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_mem_valid", 64'(mem_valid), 64'(0));
            chk("rst_cmd_ready", 64'(m_cmd_ready), 64'(0));
            chk("rst_rsp_valid", 64'(m_rsp_valid), 64'(0));
            chk("rst_err_orphan", 64'(err_orphan), 64'(0));
        end
        sys_rst_n   = 1'b1;
        m_cmd_valid = 4'h0;
        mem_rvalid  = 1'b0;
        tick();

        // Single read from master 2, response two cycles after accept.
        arb_grant   = 2'd2;
        m_cmd_valid = 4'b0100;
        m_cmd_addr[2*AW +: AW] = 32'h100;
        settle();
        chk("t2_arb_request", 64'(arb_request), 64'(4'b0100));
        chk("t2_mem_we", 64'(mem_we), 64'(0));
        issue_read(2'd2, 32'h100);
        m_cmd_valid = 4'h0;
        tick();
        rsp_expect("t2_rsp", 32'hDEAD_BEEF);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h1234_5678;
        settle();
        chk("t2_idle_rsp_valid", 64'(m_rsp_valid), 64'(0));
        chk("t2_passthru_rdata", 64'(m_rsp_rdata), 64'(32'h1234_5678));
        tick();

        // Outstanding limit from master 0; writes bypass it.
        for (int k = 0; k < 4; k++) issue_read(2'd0, 32'h200 + 32'(k));
        m_cmd_addr[0 +: AW] = 32'h204;
        settle();
        chk("t3_stall_valid", 64'(mem_valid), 64'(0));
        chk("t3_stall_ready", 64'(m_cmd_ready), 64'(0));
        tick();
        m_cmd_we = 4'b0001;
        m_cmd_wdata[0 +: DW] = 32'hCAFE_0000;
        settle();
        chk("t3_wr_valid", 64'(mem_valid), 64'(1));
        chk("t3_wr_ready", 64'(m_cmd_ready), 64'(4'b0001));
        chk("t3_wr_we", 64'(mem_we), 64'(1));
        chk("t3_wr_wdata", 64'(mem_wdata), 64'(32'hCAFE_0000));
        tick();
        m_cmd_we = 4'b0000;
        rsp_expect("t3_pop", 32'h0000_00A0);
        chk("t3_pop_stall", 64'(mem_valid), 64'(0));
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t3_fifth_valid", 64'(mem_valid), 64'(1));
        chk("t3_fifth_ready", 64'(m_cmd_ready), 64'(4'b0001));
        sb_q.push_back(2'd0);
        tick();
        m_cmd_valid = 4'h0;
        for (int k = 0; k < 4; k++) begin
            rsp_expect("t3_drain", 32'h0000_00B0 + 32'(k));
            tick();
        end
        mem_rvalid = 1'b0;

        // Interleaved masters 1, 3, 0.
        issue_read(2'd1, 32'h310);
        issue_read(2'd3, 32'h330);
        issue_read(2'd0, 32'h300);
        m_cmd_valid = 4'h0;
        rsp_expect("t4_m1", 32'h11);
        tick();
        rsp_expect("t4_m3", 32'h33);
        tick();
        rsp_expect("t4_m0", 32'h00);
        tick();
        mem_rvalid = 1'b0;

        // Full FIFO with same-cycle response and new read; pointers wrap here.
        issue_read(2'd3, 32'h530);
        issue_read(2'd2, 32'h520);
        issue_read(2'd1, 32'h510);
        issue_read(2'd0, 32'h500);
        arb_grant   = 2'd2;
        m_cmd_valid = 4'b0100;
        m_cmd_addr[2*AW +: AW] = 32'h5A0;
        rsp_expect("t5_pop_full", 32'h55);
        chk("t5_stall_valid", 64'(mem_valid), 64'(0));
        chk("t5_stall_ready", 64'(m_cmd_ready), 64'(0));
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t5_next_valid", 64'(mem_valid), 64'(1));
        chk("t5_next_ready", 64'(m_cmd_ready), 64'(4'b0100));
        chk("t5_next_addr", 64'(mem_addr), 64'(32'h5A0));
        sb_q.push_back(2'd2);
        tick();
        m_cmd_valid = 4'h0;
        for (int k = 0; k < 4; k++) begin
            rsp_expect("t5_drain", 32'h60 + 32'(k));
            tick();
        end
        mem_rvalid = 1'b0;

        // Orphan response after reset.
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77;
        settle();
        chk("t6_orphan_rsp_valid", 64'(m_rsp_valid), 64'(0));
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t6_orphan_set", 64'(err_orphan), 64'(1));
        tick();
        chk("t6_orphan_held", 64'(err_orphan), 64'(1));
        sys_rst_n = 1'b0;
        tick();
        chk("t6_orphan_clr", 64'(err_orphan), 64'(0));
        sys_rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
